// File: rtl/cc_arb_pkg.sv
// Shared constants for the CC_MUXX round-robin arbiter: sizes, quantum default,
// FSM encodings and the one-hot grant helper.
package cc_arb_pkg;

    localparam int NUM_REQ        = 8;
    localparam int DATAWIDTH_SEL  = 3;
    localparam int QUANTUM_DEF    = 16;
    localparam int DATAWIDTH_QCNT = 5;

    localparam logic ARB_IDLE  = 1'b0;
    localparam logic ARB_GRANT = 1'b1;

    function automatic logic [NUM_REQ-1:0] onehot_of(input logic [DATAWIDTH_SEL-1:0] idx);
        logic [NUM_REQ-1:0] one_v;
        one_v = {{(NUM_REQ-1){1'b0}}, 1'b1};
        return one_v << idx;
    endfunction

endpackage

// File: rtl/cc_rr_pick.sv
// Rotating priority encoder: first set request after ptr_s, wrapping, with the
// pointer position itself tried last (or skipped entirely when excl_s is set).
module cc_rr_pick
    import cc_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0]       req_s,
    input  logic [DATAWIDTH_SEL-1:0] ptr_s,
    input  logic                     excl_s,
    output logic                     found_s,
    output logic [DATAWIDTH_SEL-1:0] win_s
);

    logic [DATAWIDTH_SEL-1:0] idx_s;
    logic                     cand_s;

    // Scan farthest-first so the nearest candidate after the pointer overwrites last.
    always_comb begin
        found_s = 1'b0;
        win_s   = {DATAWIDTH_SEL{1'b0}};
        idx_s   = {DATAWIDTH_SEL{1'b0}};
        cand_s  = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx_s   = ptr_s + DATAWIDTH_SEL'(i);
            cand_s  = req_s[idx_s] & ~(excl_s & (i == NUM_REQ));
            found_s = cand_s ? 1'b1  : found_s;
            win_s   = cand_s ? idx_s : win_s;
        end
    end

endmodule

// File: rtl/cc_muxx_rr_arbiter.sv
// Round-robin owner of the CC_MUXX select: registers requests, runs the
// IDLE/GRANT FSM with a hold quantum, and drives registered grant/select/valid.
module cc_muxx_rr_arbiter
    import cc_arb_pkg::*;
#(
    parameter int QUANTUM        = QUANTUM_DEF,
    parameter int DATAWIDTH_QCNT = 5
) (
    input  logic                     CC_ARB_CLOCK_50,
    input  logic                     CC_ARB_RESET_InLow,
    input  logic [NUM_REQ-1:0]       CC_ARB_Request_In,
    output logic [NUM_REQ-1:0]       CC_ARB_Grant_Out,
    output logic [DATAWIDTH_SEL-1:0] CC_ARB_Selection_Out,
    output logic                     CC_ARB_Valid_Out,
    output logic [DATAWIDTH_SEL-1:0] CC_ARB_Owner_Out
);

    logic [NUM_REQ-1:0]        req_r;
    logic                      state_r,  state_s;
    logic [DATAWIDTH_SEL-1:0]  owner_r,  owner_s;
    logic [DATAWIDTH_QCNT-1:0] qcnt_r,   qcnt_s;
    logic [NUM_REQ-1:0]        grant_r,  grant_s;
    logic [DATAWIDTH_SEL-1:0]  sel_r,    sel_s;
    logic                      valid_r,  valid_s;
    logic                      found_s;
    logic [DATAWIDTH_SEL-1:0]  win_s;
    logic                      qlast_s;

    // While granted the owner is never its own successor, so exclude it from the search.
    cc_rr_pick u_pick (
        .req_s   (req_r),
        .ptr_s   (owner_r),
        .excl_s  (state_r),
        .found_s (found_s),
        .win_s   (win_s)
    );

    assign qlast_s = (qcnt_r == DATAWIDTH_QCNT'(QUANTUM - 1));

    // Request sampling register; isolates outputs from any combinational request path.
    always_ff @(posedge CC_ARB_CLOCK_50 or negedge CC_ARB_RESET_InLow) begin
        if (!CC_ARB_RESET_InLow) begin
            req_r <= {NUM_REQ{1'b0}};
        end else begin
            req_r <= CC_ARB_Request_In;
        end
    end

    // Next-state decision: new grant, keep, or fall back to idle.
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        qcnt_s  = qcnt_r;
        grant_s = grant_r;
        sel_s   = sel_r;
        valid_s = valid_r;
        if (found_s && ((state_r == ARB_IDLE) || !req_r[owner_r] || qlast_s)) begin
            state_s = ARB_GRANT;
            owner_s = win_s;
            qcnt_s  = {DATAWIDTH_QCNT{1'b0}};
            grant_s = onehot_of(win_s);
            sel_s   = win_s;
            valid_s = 1'b1;
        end else begin
            case (state_r)
                ARB_GRANT: begin
                    if (!req_r[owner_r]) begin
                        state_s = ARB_IDLE;
                        qcnt_s  = {DATAWIDTH_QCNT{1'b0}};
                        grant_s = {NUM_REQ{1'b0}};
                        sel_s   = {DATAWIDTH_SEL{1'b0}};
                        valid_s = 1'b0;
                    end else if (qlast_s) begin
                        qcnt_s  = {DATAWIDTH_QCNT{1'b0}};
                    end else begin
                        qcnt_s  = qcnt_r + DATAWIDTH_QCNT'(1);
                    end
                end
                default: begin
                    state_s = ARB_IDLE;
                    qcnt_s  = {DATAWIDTH_QCNT{1'b0}};
                    grant_s = {NUM_REQ{1'b0}};
                    sel_s   = {DATAWIDTH_SEL{1'b0}};
                    valid_s = 1'b0;
                end
            endcase
        end
    end

    // Arbiter state and output registers; owner resets to 7 so the first search starts at 0.
    always_ff @(posedge CC_ARB_CLOCK_50 or negedge CC_ARB_RESET_InLow) begin
        if (!CC_ARB_RESET_InLow) begin
            state_r <= ARB_IDLE;
            owner_r <= {DATAWIDTH_SEL{1'b1}};
            qcnt_r  <= {DATAWIDTH_QCNT{1'b0}};
            grant_r <= {NUM_REQ{1'b0}};
            sel_r   <= {DATAWIDTH_SEL{1'b0}};
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            qcnt_r  <= qcnt_s;
            grant_r <= grant_s;
            sel_r   <= sel_s;
            valid_r <= valid_s;
        end
    end

    assign CC_ARB_Grant_Out     = grant_r;
    assign CC_ARB_Selection_Out = sel_r;
    assign CC_ARB_Valid_Out     = valid_r;
    assign CC_ARB_Owner_Out     = owner_r;

endmodule

// File: tb/tb_cc_muxx_rr_arbiter.sv
// Scoreboard bench for cc_muxx_rr_arbiter: directed scenarios then random
// requests, checked against a cycle-level round-robin reference model.
module tb_cc_muxx_rr_arbiter;

    localparam int Q = 4;

    typedef struct {
        logic [7:0] grant;
        logic [2:0] sel;
        logic       valid;
        logic [2:0] owner;
    } exp_t;

    typedef struct {
        bit         rst;
        logic [7:0] req;
        int         cyc;
    } step_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
    logic [2:0] owner;

    int n_checks;
    int n_fail;
    exp_t exp_q[$];

    // Reference model state: owner index, busy flag, cycles held, last sampled request.
    int         m_owner;
    bit         m_busy;
    int         m_held;
    logic [7:0] m_sreq;

    cc_muxx_rr_arbiter #(.QUANTUM(Q), .DATAWIDTH_QCNT(5)) dut (
        .CC_ARB_CLOCK_50      (clk),
        .CC_ARB_RESET_InLow   (rst_n),
        .CC_ARB_Request_In    (req),
        .CC_ARB_Grant_Out     (grant),
        .CC_ARB_Selection_Out (sel),
        .CC_ARB_Valid_Out     (valid),
        .CC_ARB_Owner_Out     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit find_next(input logic [7:0] s, input int ptr, input bit excl,
                                     output int w);
        w = 0;
        for (int i = 1; i <= 8; i++) begin
            int idx;
            idx = (ptr + i) % 8;
            if (!(i == 8 && excl) && s[idx]) begin
                w = idx;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Advance the model over one rising edge (using the request sampled on the previous edge).
    task automatic model_edge();
        int  w;
        bit  f;
        exp_t e;
        if (!rst_n) begin
            m_busy = 0; m_owner = 7; m_held = 0; m_sreq = 8'h00;
        end else begin
            if (!m_busy) begin
                if (find_next(m_sreq, m_owner, 1'b0, w)) begin
                    m_busy = 1; m_owner = w; m_held = 1;
                end
            end else if (!m_sreq[m_owner]) begin
                if (find_next(m_sreq, m_owner, 1'b1, w)) begin
                    m_owner = w; m_held = 1;
                end else begin
                    m_busy = 0;
                end
            end else if (m_held == Q) begin
                f = find_next(m_sreq, m_owner, 1'b1, w);
                if (f) m_owner = w;
                m_held = 1;
            end else begin
                m_held++;
            end
            m_sreq = req;
        end
        e.valid = m_busy;
        e.grant = m_busy ? (8'h01 << m_owner) : 8'h00;
        e.sel   = m_busy ? 3'(m_owner) : 3'd0;
        e.owner = 3'(m_owner);
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit r, input logic [7:0] rq);
        @(negedge clk);
        if (r) begin
            rst_n = 1'b0;
            #1;
            check("rst_grant", int'(grant), 0);
            check("rst_valid", int'(valid), 0);
            check("rst_sel",   int'(sel),   0);
        end else begin
            rst_n = 1'b1;
        end
        req = rq;
        model_edge();
    endtask

    // Monitor: compare every post-edge output against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant", int'(grant), int'(e.grant));
                check("sel",   int'(sel),   int'(e.sel));
                check("valid", int'(valid), int'(e.valid));
                check("owner", int'(owner), int'(e.owner));
                check("onehot0", int'($onehot0(grant)), 1);
                check("valid_eq_or", int'(valid), int'(|grant));
            end
        end
    end

    step_t plan[$];

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; req = 8'h00;
        m_busy = 0; m_owner = 7; m_held = 0; m_sreq = 8'h00;
        plan = '{
            '{1'b1, 8'hFF, 3}, '{1'b0, 8'h01, 4},
            '{1'b0, 8'hFF, 40},
            '{1'b0, 8'h00, 3}, '{1'b0, 8'h04, 3}, '{1'b0, 8'h24, 1}, '{1'b0, 8'h20, 4},
            '{1'b0, 8'h00, 3}, '{1'b0, 8'h08, 40},
            '{1'b0, 8'h00, 3}, '{1'b0, 8'h40, 4}, '{1'b0, 8'h41, 2}, '{1'b0, 8'h01, 4},
            '{1'b0, 8'h41, 6}, '{1'b0, 8'h40, 4},
            '{1'b0, 8'h00, 3}, '{1'b0, 8'h20, 4}, '{1'b1, 8'h20, 2}, '{1'b0, 8'h21, 5}
        };
        foreach (plan[k]) begin
            for (int c = 0; c < plan[k].cyc; c++) drive(plan[k].rst, plan[k].req);
        end
        for (int seg = 0; seg < 120; seg++) begin
            logic [7:0] rr;
            int len;
            bit rs;
            rr  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rr = rr & 8'($urandom);
            len = $urandom_range(1, 8);
            rs  = ($urandom_range(0, 40) == 0);
            for (int c = 0; c < len; c++) drive(rs && (c == 0), rr);
        end
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
